mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline stage for the RISC-V pipeline, replacing the fixed 32-bit MEM/WB register.
- Adds a valid/ready handshake and an optional 2-entry skid buffer.
- Adds flush, and load-data extraction/extension performed at capture.
- Adds writeback-source selection, x0 write suppression and a retired-instruction counter.
- Sits between data memory/ALU result path and register file write port; also feeds the forwarding unit.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_ADDR_W, 5, register index width
SKID_EN, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single entry, in_ready = out_ready | ~out_valid
CNT_W, 32, retire counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  discard all held entries
in_valid  input  1  MEM-stage bundle valid
in_ready  output  1  stage can accept a bundle this cycle
in_read_data  input  XLEN  raw word from data memory
in_alu_result  input  XLEN  ALU result / memory address
in_pc_plus4  input  XLEN  return address for JAL/JALR
in_rd  input  REG_ADDR_W  destination register
in_reg_write  input  1  instruction writes rd
in_wb_sel  input  2  00 ALU, 01 load, 10 pc+4, 11 reserved (treated as ALU)
in_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (011/110 LD/LWU when XLEN=64)
out_valid  output  1  WB bundle valid
out_ready  input  1  WB consumer accepts (regfile ties high)
out_rd  output  REG_ADDR_W  destination register
out_wb_data  output  XLEN  selected, extended writeback value
out_reg_write  output  1  out_valid & reg_write & (rd != 0)
out_misalign  output  1  load with unaligned address for its size
retire_count  output  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst=1, asynchronous):
  - out_valid=0, out_rd=0, out_wb_data=0, out_reg_write=0, out_misalign=0, retire_count=0.
  - Skid entry empty; in_ready=1 once rst deasserts.
- Capture on in_valid & in_ready. Result is formed before registering; outputs are registered, latency 1 cycle when not stalled.
- Result formation:
  - wb_sel 01: load extraction uses byte offset in_alu_result[1:0] (XLEN=64: [2:0]).
    - Byte = read_data[8*off +: 8].
    - Half = read_data[16*off[..1] +: 16].
    - LB/LH sign-extend to XLEN; LBU/LHU zero-extend; LW passes through (XLEN=64: sign-extend).
  - wb_sel 10: pc_plus4. Otherwise: alu_result.
- out_misalign (registered with the bundle):
  - Set for a load only: LH/LHU with off[0]=1, LW with off[1:0]!=0.
  - Data still produced from aligned lane; the consumer decides the trap.
- out_reg_write suppressed when rd=0 even if in_reg_write=1; out_wb_data still reflects the computed value.
- Output handshake: bundle completes on out_valid & out_ready, and retire_count increments by 1 (wraps modulo 2^CNT_W).
- Output stall: out_valid & ~out_ready holds all outputs stable.
- SKID_EN=1:
  - in_ready = ~skid_full (registered).
  - A capture during an output stall goes to the skid entry; skid then drains to output on the next handshake.
  - Order is strictly preserved.
  - Full throughput when out_ready=1.
- SKID_EN=0: single entry; in_ready = out_ready | ~out_valid (combinational).
- flush:
  - Next edge: out_valid=0, skid empty, out_reg_write=0.
  - Flush beats a simultaneous capture (incoming bundle dropped).
  - A handshake in the same cycle still counts in retire_count.
- Simultaneous output handshake + capture with skid empty: new bundle goes directly to output register, no bubble.
- Reset mid-stall: all entries discarded; retire_count cleared.

Test Plan:
- Reset, then in_valid=1, wb_sel=00, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle out_valid=1, out_rd=5, out_wb_data=0x0000_1234, out_reg_write=1, retire_count=1 after handshake.
- Load LB, read_data=0x80FF_7F01, alu_result off=1 -> out_wb_data=0x0000_007F; off=2 -> 0xFFFF_FFFF; LBU off=3 -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF; LH off=1 -> out_misalign=1.
- rd=0, reg_write=1, wb_sel=10, pc_plus4=0x100 -> out_valid=1, out_wb_data=0x100, out_reg_write=0.
- SKID_EN=1, out_ready=0 while A then B presented:
  - A in output, B in skid, in_ready=0, C held.
  - Then out_ready=1 -> A, B, C emitted in consecutive cycles, retire_count +3.
- Flush with out_valid=1, skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming bundle never appears.
- Back-to-back 10 bundles, out_ready=1 -> 10 outputs in 10 consecutive cycles; CNT_W=4 with 17 retirements -> retire_count=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: load extraction, writeback-source select, valid/ready
// handshake with an optional skid entry, flush and a retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID_EN    = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_read_data,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc_plus4,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_funct3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_wb_data,
    output logic                  out_reg_write,
    output logic                  out_misalign,
    output logic [CNT_W-1:0]      retire_count
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic [OFF_W-1:0] w_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_wordSext;
    logic [XLEN-1:0]  w_wordZext;
    logic [XLEN-1:0]  w_loadData;
    logic [XLEN-1:0]  w_result;
    logic             w_misalign;
    logic             w_regWrite;
    logic             w_capture;
    logic             w_outFire;

    assign w_off  = in_alu_result[OFF_W-1:0];
    assign w_byte = in_read_data[{w_off, 3'b000} +: 8];
    assign w_half = in_read_data[{w_off[OFF_W-1:1], 4'b0000} +: 16];

    // Word loads only pick a lane on a 64-bit datapath; on 32 bits the word is the whole bus.
    generate
        if (XLEN == 64) begin : g_word64
            logic [31:0] w_word;
            assign w_word     = in_read_data[{w_off[2], 5'b00000} +: 32];
            assign w_wordSext = {{(XLEN-32){w_word[31]}}, w_word};
            assign w_wordZext = {{(XLEN-32){1'b0}}, w_word};
        end else begin : g_word32
            assign w_wordSext = in_read_data;
            assign w_wordZext = in_read_data;
        end
    endgenerate

    always_comb begin
        w_loadData = in_read_data;
        w_misalign = 1'b0;
        case (in_funct3)
            3'b000: w_loadData = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001: begin
                w_loadData = {{(XLEN-16){w_half[15]}}, w_half};
                w_misalign = w_off[0];
            end
            3'b100: w_loadData = {{(XLEN-8){1'b0}}, w_byte};
            3'b101: begin
                w_loadData = {{(XLEN-16){1'b0}}, w_half};
                w_misalign = w_off[0];
            end
            3'b010: begin
                w_loadData = w_wordSext;
                w_misalign = |w_off[1:0];
            end
            3'b110: begin
                w_loadData = w_wordZext;
                w_misalign = |w_off[1:0];
            end
            3'b011: w_misalign = (XLEN == 64) && (|w_off);
            default: w_loadData = in_read_data;
        endcase
        case (in_wb_sel)
            2'b01:   w_result = w_loadData;
            2'b10:   w_result = in_pc_plus4;
            default: w_result = in_alu_result;
        endcase
        if (in_wb_sel != 2'b01) begin
            w_misalign = 1'b0;
        end
    end

    assign w_regWrite = in_reg_write && (in_rd != '0);

    logic                  r_outValid;
    logic [REG_ADDR_W-1:0] r_outRd;
    logic [XLEN-1:0]       r_outData;
    logic                  r_outRegWr;
    logic                  r_outMis;
    logic                  r_skidValid;
    logic [REG_ADDR_W-1:0] r_skidRd;
    logic [XLEN-1:0]       r_skidData;
    logic                  r_skidRegWr;
    logic                  r_skidMis;
    logic [CNT_W-1:0]      r_retireCount;

    assign in_ready  = (SKID_EN != 0) ? ~r_skidValid : (out_ready | ~r_outValid);
    assign w_capture = in_valid & in_ready;
    assign w_outFire = r_outValid & out_ready;

    // Output register refills from the skid entry first so bundle order is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid    <= 1'b0;
            r_outRd       <= '0;
            r_outData     <= '0;
            r_outRegWr    <= 1'b0;
            r_outMis      <= 1'b0;
            r_skidValid   <= 1'b0;
            r_skidRd      <= '0;
            r_skidData    <= '0;
            r_skidRegWr   <= 1'b0;
            r_skidMis     <= 1'b0;
            r_retireCount <= '0;
        end else begin
            r_retireCount <= r_retireCount + {{(CNT_W-1){1'b0}}, w_outFire};
            if (flush) begin
                r_outValid  <= 1'b0;
                r_outRegWr  <= 1'b0;
                r_skidValid <= 1'b0;
            end else if (w_outFire || !r_outValid) begin
                if (r_skidValid) begin
                    r_outValid  <= 1'b1;
                    r_outRd     <= r_skidRd;
                    r_outData   <= r_skidData;
                    r_outRegWr  <= r_skidRegWr;
                    r_outMis    <= r_skidMis;
                    r_skidValid <= 1'b0;
                end else if (w_capture) begin
                    r_outValid <= 1'b1;
                    r_outRd    <= in_rd;
                    r_outData  <= w_result;
                    r_outRegWr <= w_regWrite;
                    r_outMis   <= w_misalign;
                end else begin
                    r_outValid <= 1'b0;
                    r_outRegWr <= 1'b0;
                end
            end else if (w_capture) begin
                r_skidValid <= 1'b1;
                r_skidRd    <= in_rd;
                r_skidData  <= w_result;
                r_skidRegWr <= w_regWrite;
                r_skidMis   <= w_misalign;
            end
        end
    end

    assign out_valid     = r_outValid;
    assign out_rd        = r_outRd;
    assign out_wb_data   = r_outData;
    assign out_reg_write = r_outValid & r_outRegWr;
    assign out_misalign  = r_outMis;
    assign retire_count  = r_retireCount;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: loads, writeback select, skid stall, flush,
// back-to-back streaming and counter wrap on a 4-bit counter instance.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_read_data;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_wb_data;
    logic        out_reg_write;
    logic        out_misalign;
    logic [31:0] retire_count;

    logic        inReady4;
    logic        outValid4;
    logic [4:0]  outRd4;
    logic [31:0] outWbData4;
    logic        outRegWrite4;
    logic        outMisalign4;
    logic [3:0]  retireCount4;

    int checkCount = 0;
    int passCount  = 0;

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .SKID_EN(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_wb_data(out_wb_data), .out_reg_write(out_reg_write),
        .out_misalign(out_misalign), .retire_count(retire_count)
    );

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .SKID_EN(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(inReady4),
        .in_read_data(in_read_data), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .out_valid(outValid4), .out_ready(out_ready), .out_rd(outRd4),
        .out_wb_data(outWbData4), .out_reg_write(outRegWrite4),
        .out_misalign(outMisalign4), .retire_count(retireCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rd, input logic regWrite,
                                 input logic [1:0] wbSel, input logic [2:0] funct3,
                                 input logic [31:0] readData, input logic [31:0] alu,
                                 input logic [31:0] pc);
        in_valid      = valid;
        in_rd         = rd;
        in_reg_write  = regWrite;
        in_wb_sel     = wbSel;
        in_funct3     = funct3;
        in_read_data  = readData;
        in_alu_result = alu;
        in_pc_plus4   = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] expData, input logic expMis);
        applyStimulus(1'b1, 5'd7, 1'b1, 2'b01, f3, 32'h80FF_7F01, {30'h0000_0400, off}, 32'h0);
        step();
        checkOutput({tag, "_data"}, 64'(out_wb_data), 64'(expData));
        checkOutput({tag, "_mis"}, 64'(out_misalign), 64'(expMis));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_wb_data), 64'd0);
        checkOutput("rst_rd", 64'(out_rd), 64'd0);
        checkOutput("rst_regwr", 64'(out_reg_write), 64'd0);
        checkOutput("rst_mis", 64'(out_misalign), 64'd0);
        checkOutput("rst_count", 64'(retire_count), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_inready", 64'(in_ready), 64'd1);

        // ALU writeback, one cycle latency
        applyStimulus(1'b1, 5'd5, 1'b1, 2'b00, 3'b010, 32'h0, 32'h0000_1234, 32'h0);
        step();
        checkOutput("alu_valid", 64'(out_valid), 64'd1);
        checkOutput("alu_rd", 64'(out_rd), 64'd5);
        checkOutput("alu_data", 64'(out_wb_data), 64'h1234);
        checkOutput("alu_regwr", 64'(out_reg_write), 64'd1);
        checkOutput("alu_count0", 64'(retire_count), 64'd0);

        loadCheck("lb_off1", 3'b000, 2'd1, 32'h0000_007F, 1'b0);
        checkOutput("alu_count1", 64'(retire_count), 64'd1);
        loadCheck("lb_off2", 3'b000, 2'd2, 32'hFFFF_FFFF, 1'b0);
        loadCheck("lbu_off3", 3'b100, 2'd3, 32'h0000_0080, 1'b0);
        loadCheck("lh_off2", 3'b001, 2'd2, 32'hFFFF_80FF, 1'b0);
        loadCheck("lh_off1", 3'b001, 2'd1, 32'h0000_7F01, 1'b1);
        loadCheck("lhu_off2", 3'b101, 2'd2, 32'h0000_80FF, 1'b0);
        loadCheck("lw_off0", 3'b010, 2'd0, 32'h80FF_7F01, 1'b0);
        loadCheck("lw_off2", 3'b010, 2'd2, 32'h80FF_7F01, 1'b1);
        loadCheck("lb_off0", 3'b000, 2'd0, 32'h0000_0001, 1'b0);

        applyStimulus(1'b1, 5'd0, 1'b1, 2'b10, 3'b000, 32'h0, 32'h5555, 32'h0000_0100);
        step();
        checkOutput("pc4_valid", 64'(out_valid), 64'd1);
        checkOutput("pc4_data", 64'(out_wb_data), 64'h100);
        checkOutput("pc4_x0_regwr", 64'(out_reg_write), 64'd0);

        applyStimulus(1'b1, 5'd9, 1'b1, 2'b11, 3'b001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h40);
        step();
        checkOutput("sel11_data", 64'(out_wb_data), 64'h3);
        checkOutput("sel11_mis", 64'(out_misalign), 64'd0);

        in_valid = 1'b0;
        step();
        checkOutput("idle_valid", 64'(out_valid), 64'd0);
        checkOutput("idle_count", 64'(retire_count), 64'd12);

        // Stall with A in output, B in skid, C held at the input
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000A, 32'h0);
        step();
        checkOutput("skid_a_out", 64'(out_wb_data), 64'hA);
        checkOutput("skid_a_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 5'd2, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000B, 32'h0);
        step();
        checkOutput("skid_b_held_out", 64'(out_wb_data), 64'hA);
        checkOutput("skid_full_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000C, 32'h0);
        step();
        checkOutput("skid_stall_out", 64'(out_wb_data), 64'hA);
        checkOutput("skid_stall_rd", 64'(out_rd), 64'd1);
        checkOutput("skid_stall_count", 64'(retire_count), 64'd12);
        out_ready = 1'b1;
        step();
        checkOutput("drain_b", 64'(out_wb_data), 64'hB);
        checkOutput("drain_b_valid", 64'(out_valid), 64'd1);
        step();
        checkOutput("drain_c", 64'(out_wb_data), 64'hC);
        checkOutput("drain_c_rd", 64'(out_rd), 64'd3);
        in_valid = 1'b0;
        step();
        checkOutput("drain_empty", 64'(out_valid), 64'd0);
        checkOutput("drain_count", 64'(retire_count), 64'd15);

        // Flush with output valid, skid full and a bundle waiting
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd8, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000D, 32'h0);
        step();
        applyStimulus(1'b1, 5'd8, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000E, 32'h0);
        step();
        checkOutput("fl_skid_full", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 5'd8, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_000F, 32'h0);
        flush = 1'b1;
        step();
        checkOutput("fl_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_ready", 64'(in_ready), 64'd1);
        checkOutput("fl_regwr", 64'(out_reg_write), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("fl_nothing", 64'(out_valid), 64'd0);
        checkOutput("fl_count", 64'(retire_count), 64'd15);

        applyStimulus(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_0077, 32'h0);
        flush = 1'b1;
        step();
        checkOutput("fl_beats_cap", 64'(out_valid), 64'd0);
        flush = 1'b0;
        applyStimulus(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_0088, 32'h0);
        step();
        checkOutput("fl_h_out", 64'(out_wb_data), 64'h88);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("fl_hs_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_hs_count", 64'(retire_count), 64'd16);

        // Asynchronous reset during an output stall
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd6, 1'b1, 2'b00, 3'b000, 32'h0, 32'h0000_0099, 32'h0);
        step();
        checkOutput("mid_stall_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_count", 64'(retire_count), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        // 17 back-to-back bundles, one output per cycle
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 1'b1, 2'b00, 3'b010, 32'h0, 32'h100 + 32'(i), 32'h0);
            step();
            checkOutput($sformatf("b2b_valid_%0d", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("b2b_data_%0d", i), 64'(out_wb_data), 64'h100 + 64'(i));
        end
        in_valid = 1'b0;
        step();
        checkOutput("b2b_done", 64'(out_valid), 64'd0);
        checkOutput("b2b_count", 64'(retire_count), 64'd17);
        checkOutput("wrap_count4", 64'(retireCount4), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
